// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and parity helper
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Expected parity bit for up to 9 data bits; callers zero-fill unused upper bits.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    case (mode)
      PAR_EVEN: parity_bit = ^data;
      PAR_ODD:  parity_bit = ~^data;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with configurable reset value
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with parity/stop checks and valid/ready output
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int              TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]   MID_BIT   = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [1:0]      PMODE     = (PARITY_MODE == 1) ? PAR_EVEN :
                                          (PARITY_MODE == 2) ? PAR_ODD  : PAR_NONE;

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 dperr_q, dperr_d;
  logic                 dferr_q, dferr_d;
  logic                 ovr_q, ovr_d;
  logic                 done;
  logic [8:0]           data_ext;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    dperr_d  = dperr_q;
    dferr_d  = dferr_q;
    ovr_d    = ovr_q;
    done     = 1'b0;
    data_ext = '0;
    data_ext[DATA_BITS-1:0] = shift_q;

    if (dvalid_q && dout_ready) begin
      dvalid_d = 1'b0;
      ovr_d    = 1'b0;
    end

    if (clk_en) begin
      tcnt_d = tcnt_q + 1'b1;
      case (state_q)
        RX_IDLE: begin
          tcnt_d = '0;
          if (!rx_s) state_d = RX_START;
        end
        RX_START: begin
          if (tcnt_q == MID_START) begin
            tcnt_d = '0;
            if (rx_s) begin
              state_d = RX_IDLE;
            end else begin
              bcnt_d  = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              state_d = RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (tcnt_q == MID_BIT) begin
            tcnt_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == LAST_DATA) begin
              bcnt_d  = '0;
              state_d = (PMODE != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          // shift_q already holds every data bit by the time the parity bit is sampled
          if (tcnt_q == MID_BIT) begin
            tcnt_d  = '0;
            perr_d  = (rx_s != parity_bit(data_ext, PMODE));
            state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (tcnt_q == MID_BIT) begin
            tcnt_d = '0;
            bcnt_d = bcnt_q + 1'b1;
            if (!rx_s) ferr_d = 1'b1;
            if (bcnt_q == LAST_STOP) begin
              bcnt_d  = '0;
              state_d = RX_IDLE;
              done    = 1'b1;
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    // A finished frame only replaces the held word if it is free or leaving this cycle.
    if (done) begin
      if (!dvalid_q || dout_ready) begin
        dout_d   = shift_q;
        dperr_d  = perr_q;
        dferr_d  = ferr_q | ~rx_s;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RX_IDLE;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      dperr_q  <= 1'b0;
      dferr_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      dperr_q  <= dperr_d;
      dferr_q  <= dferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dvalid_q;
  assign parity_err = dperr_q;
  assign frame_err  = dferr_q;
  assign overrun    = ovr_q;
  assign rx_busy    = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized self-checking bench for uart_rx_os (two parameter sets)
module tb_uart_rx_os;

  localparam int OS0 = 16;
  localparam int DB1 = 7;
  localparam int OS1 = 8;

  logic       clk = 1'b0;
  logic       rst, clk_en, rx0, rx1, rdy0, rdy1;
  logic [7:0] dout0;
  logic       dv0, pe0, fe0, ov0, bz0;
  logic [6:0] dout1;
  logic       dv1, pe1, fe1, ov1, bz1;
  int         checks = 0;
  int         errors = 0;
  bit         fast = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .rx(rx0),
    .dout(dout0), .dout_valid(dv0), .dout_ready(rdy0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .rx_busy(bz0)
  );

  uart_rx_os #(.DATA_BITS(DB1), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(OS1)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .rx(rx1),
    .dout(dout1), .dout_valid(dv1), .dout_ready(rdy1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .rx_busy(bz1)
  );

  // Line-level frame model: sel 0 = 8 data, even parity, 1 stop; sel 1 = 7 data, odd parity, 2 stops.
  function automatic void make_frame(input int sel, input logic [8:0] data, input bit bad_par,
                                     input logic [1:0] stop_low, output logic [15:0] bits,
                                     output int n, output bit exp_fe);
    int nd, ns, ones;
    bit par;
    nd = (sel == 0) ? 8 : DB1;
    ns = (sel == 0) ? 1 : 2;
    ones = 0;
    for (int i = 0; i < nd; i++) ones += int'(data[i]);
    par = (sel == 0) ? (ones % 2 == 1) : (ones % 2 == 0);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) bits[1 + i] = data[i];
    bits[1 + nd] = par ^ bad_par;
    exp_fe = 1'b0;
    for (int s = 0; s < ns; s++) begin
      bits[2 + nd + s] = ~stop_low[s];
      exp_fe |= stop_low[s];
    end
    n = 2 + nd + ns;
  endfunction

  task automatic tick();
    clk_en = 1'b1;
    @(negedge clk);
    if (!fast) begin
      clk_en = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int sel, input logic [15:0] bits, input int n, output int rise);
    int os, idx;
    os = (sel == 0) ? OS0 : OS1;
    idx = 0;
    rise = -1;
    for (int b = 0; b < n; b++) begin
      for (int t = 0; t < os; t++) begin
        if (rise < 0 && ((sel == 0) ? dv0 : dv1)) rise = idx;
        if (sel == 0) rx0 = bits[b]; else rx1 = bits[b];
        tick();
        idx++;
      end
    end
    rx0 = 1'b1;
    rx1 = 1'b1;
    for (int t = 0; t < os + 4; t++) begin
      if (rise < 0 && ((sel == 0) ? dv0 : dv1)) rise = idx;
      tick();
      idx++;
    end
    clk_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL rst_dout0: got %h expected 00", dout0); end
    checks++; if ({dv0, pe0, fe0, ov0, bz0} !== 5'b0) begin errors++; $display("FAIL rst_flags0: got %b expected 00000", {dv0, pe0, fe0, ov0, bz0}); end
    checks++; if (dout1 !== 7'h00) begin errors++; $display("FAIL rst_dout1: got %h expected 00", dout1); end
    checks++; if ({dv1, pe1, fe1, ov1, bz1} !== 5'b0) begin errors++; $display("FAIL rst_flags1: got %b expected 00000", {dv1, pe1, fe1, ov1, bz1}); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if ({dv0, bz0, dv1, bz1} !== 4'b0) begin errors++; $display("FAIL rst_idle: got %b expected 0000", {dv0, bz0, dv1, bz1}); end
  endtask

  task automatic test_latency_a5();
    logic [15:0] bits; int n, rise; bit efe;
    make_frame(0, 9'h0A5, 1'b0, 2'b00, bits, n, efe);
    fast = 1'b1;
    send_frame(0, bits, n, rise);
    fast = 1'b0;
    // two sync clocks, then OS/2 + 10*OS ticks to completion, then one clock to dout_valid
    checks++; if (rise !== 2 + OS0 / 2 + 10 * OS0 + 1) begin errors++; $display("FAIL a5_latency: got %0d expected %0d", rise, 2 + OS0 / 2 + 10 * OS0 + 1); end
    checks++; if (dout0 !== 8'hA5) begin errors++; $display("FAIL a5_dout: got %h expected a5", dout0); end
    checks++; if ({dv0, pe0, fe0} !== 3'b100) begin errors++; $display("FAIL a5_flags: got %b expected 100", {dv0, pe0, fe0}); end
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0;
    checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL a5_accept: got %b expected 0", dv0); end
  endtask

  task automatic test_odd_parity_err();
    logic [15:0] bits; int n, rise; bit efe;
    make_frame(1, 9'h041, 1'b1, 2'b00, bits, n, efe);
    send_frame(1, bits, n, rise);
    checks++; if (dout1 !== 7'h41) begin errors++; $display("FAIL par_dout: got %h expected 41", dout1); end
    checks++; if ({dv1, pe1, fe1} !== 3'b110) begin errors++; $display("FAIL par_flags: got %b expected 110", {dv1, pe1, fe1}); end
    rdy1 = 1'b1; @(negedge clk); rdy1 = 1'b0;
  endtask

  task automatic test_stop2_low();
    logic [15:0] bits; int n, rise; bit efe;
    make_frame(1, 9'h03C, 1'b0, 2'b10, bits, n, efe);
    send_frame(1, bits, n, rise);
    checks++; if (dout1 !== 7'h3C) begin errors++; $display("FAIL stop_dout: got %h expected 3c", dout1); end
    checks++; if ({dv1, pe1, fe1} !== 3'b101) begin errors++; $display("FAIL stop_flags: got %b expected 101", {dv1, pe1, fe1}); end
    rdy1 = 1'b1; @(negedge clk); rdy1 = 1'b0;
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL stop_accept: got %b expected 0", dv1); end
  endtask

  task automatic test_glitch();
    logic [15:0] bits; int n, rise; bit efe, saw;
    saw = 1'b0;
    rx0 = 1'b0;
    for (int t = 0; t < 4; t++) begin tick(); saw |= bz0; end
    rx0 = 1'b1;
    for (int t = 0; t < OS0; t++) begin tick(); saw |= bz0; end
    checks++; if (saw !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got %b expected 1", saw); end
    checks++; if ({dv0, bz0} !== 2'b00) begin errors++; $display("FAIL glitch_idle: got %b expected 00", {dv0, bz0}); end
    make_frame(0, 9'h055, 1'b0, 2'b00, bits, n, efe);
    send_frame(0, bits, n, rise);
    checks++; if ({dout0, dv0, pe0, fe0} !== {8'h55, 3'b100}) begin errors++; $display("FAIL glitch_next: got %h/%b expected 55/100", dout0, {dv0, pe0, fe0}); end
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0;
  endtask

  task automatic test_overrun();
    logic [15:0] bits; int n, rise; bit efe;
    make_frame(0, 9'h011, 1'b0, 2'b00, bits, n, efe);
    send_frame(0, bits, n, rise);
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b expected 0", ov0); end
    make_frame(0, 9'h022, 1'b1, 2'b01, bits, n, efe);
    send_frame(0, bits, n, rise);
    checks++; if (dout0 !== 8'h11) begin errors++; $display("FAIL ovr_dout: got %h expected 11", dout0); end
    checks++; if ({dv0, ov0, pe0, fe0} !== 4'b1100) begin errors++; $display("FAIL ovr_flags: got %b expected 1100", {dv0, ov0, pe0, fe0}); end
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0;
    checks++; if ({dv0, ov0} !== 2'b00) begin errors++; $display("FAIL ovr_clear: got %b expected 00", {dv0, ov0}); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits; int n, rise; bit efe;
    make_frame(0, 9'h05A, 1'b1, 2'b00, bits, n, efe);
    send_frame(0, bits, n, rise);
    make_frame(0, 9'h0FF, 1'b0, 2'b00, bits, n, efe);
    for (int b = 0; b < 5; b++)
      for (int t = 0; t < OS0; t++) begin rx0 = bits[b]; tick(); end
    checks++; if ({bz0, dv0, pe0} !== 3'b111) begin errors++; $display("FAIL rmid_before: got %b expected 111", {bz0, dv0, pe0}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({dout0, dv0, pe0, fe0, ov0, bz0} !== 13'b0) begin errors++; $display("FAIL rmid_outputs: got %h/%b expected 00/00000", dout0, {dv0, pe0, fe0, ov0, bz0}); end
    rst = 1'b0;
    rx0 = 1'b1;
    for (int t = 0; t < 2 * OS0; t++) tick();
    checks++; if ({dv0, bz0} !== 2'b00) begin errors++; $display("FAIL rmid_noword: got %b expected 00", {dv0, bz0}); end
    make_frame(0, 9'h081, 1'b0, 2'b00, bits, n, efe);
    send_frame(0, bits, n, rise);
    checks++; if ({dout0, dv0, pe0, fe0, ov0} !== {8'h81, 4'b1000}) begin errors++; $display("FAIL rmid_after: got %h/%b expected 81/1000", dout0, {dv0, pe0, fe0, ov0}); end
    rdy0 = 1'b1; @(negedge clk); rdy0 = 1'b0;
  endtask

  task automatic test_random(input int sel, input int iters);
    logic [15:0] bits; int n, rise; bit efe, bad;
    logic [8:0] data, obs_d;
    logic [1:0] sl;
    logic [3:0] obs_f;
    for (int i = 0; i < iters; i++) begin
      data = 9'($urandom) & ((sel == 0) ? 9'h0FF : 9'h07F);
      bad  = ($urandom_range(0, 3) == 0);
      sl   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fast = 1'($urandom_range(0, 1));
      make_frame(sel, data, bad, sl, bits, n, efe);
      send_frame(sel, bits, n, rise);
      fast = 1'b0;
      obs_d = (sel == 0) ? {1'b0, dout0} : {2'b00, dout1};
      obs_f = (sel == 0) ? {dv0, pe0, fe0, ov0} : {dv1, pe1, fe1, ov1};
      checks++; if (obs_d !== data) begin errors++; $display("FAIL rand%0d_dout[%0d]: got %h expected %h", sel, i, obs_d, data); end
      checks++; if (obs_f !== {1'b1, bad, efe, 1'b0}) begin errors++; $display("FAIL rand%0d_flags[%0d]: got %b expected %b", sel, i, obs_f, {1'b1, bad, efe, 1'b0}); end
      if (sel == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0; rdy1 = 1'b0;
      checks++; if (((sel == 0) ? dv0 : dv1) !== 1'b0) begin errors++; $display("FAIL rand%0d_accept[%0d]: got 1 expected 0", sel, i); end
    end
  endtask

  initial begin
    test_reset();
    test_latency_a5();
    test_odd_parity_err();
    test_stop2_low();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_random(0, 12);
    test_random(1, 12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver; next generation of the team's fixed 8N1-style receiver. It samples `rx` at the mid-point of each bit using an OVERSAMPLE× tick and rejects false starts. Data width, parity mode and stop-bit count are configurable. It presents each received word on a valid/ready handshake with per-word error flags and an overrun indication. It sits between the pad-side `rx` line and the downstream byte FIFO or command parser.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal values 1 or 2.
- `OVERSAMPLE`, 16: `clk_en` ticks per bit; even, ≥ 4.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `clk_en` in 1: oversample tick, one `clk` wide, at OVERSAMPLE × baud.
- `rx` in 1: serial input, asynchronous, idle high.
- `dout` out DATA_BITS: received word, LSB = first data bit.
- `dout_valid` out 1: word available.
- `dout_ready` in 1: consumer accepts word.
- `parity_err` out 1: parity mismatch for the presented word; valid only while `dout_valid`.
- `frame_err` out 1: any stop bit sampled low for the presented word; valid only while `dout_valid`.
- `overrun` out 1: a completed frame was dropped because the previous word was not yet accepted.
- `rx_busy` out 1: a frame is in progress (state ≠ IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP. A tick counter `tcnt` (width clog2(OVERSAMPLE)) and a bit counter `bcnt` advance only on `clk_en`.
- **IDLE:** on a tick with `rx_s`=0, clear `tcnt` and go to START.
- **START:** on the tick where `tcnt` = OVERSAMPLE/2−1 (mid start bit):
  - if `rx_s`=1 → false start; return to IDLE with no output and no flags.
  - otherwise clear `tcnt`, clear `bcnt`, go to DATA.
- **DATA:** sample on the tick where `tcnt` = OVERSAMPLE−1 (mid-bit), then clear `tcnt`. Shift the sample in, LSB first. After DATA_BITS samples, go to PARITY if PARITY_MODE≠0, else STOP.
- **PARITY:** sample at mid-bit.
  - Even: error if sample ≠ XOR of data bits.
  - Odd: error if sample ≠ XNOR of data bits.
  - Parity is computed from the fully assembled shift register, never a stale copy.
- **STOP:** sample STOP_BITS bits at mid-bit. Any low sample sets the internal frame-error bit. The last stop sample completes the frame and the FSM returns to IDLE on that same tick, so a start bit can be detected half a bit later.
- **Frame completion:**
  - If `dout_valid`=0 or `dout_ready`=1 in that cycle: load `dout`, `parity_err` and `frame_err`, and set `dout_valid`=1.
  - Otherwise, discard the new frame, keep the old word, and set `overrun`=1.
- **Handshake:** a transfer occurs when `dout_valid` && `dout_ready`. `dout_valid` then clears next cycle unless a completion loads a new word in the same cycle; in that case it stays high with the new data. `dout`, `parity_err` and `frame_err` are stable while `dout_valid` && !`dout_ready`.
- **Overrun** is sticky. It clears on the next transfer.
- PARITY_MODE values outside 0..2 behave as 0.

## Timing
- **Reset values:** `dout`=0, `dout_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0, state IDLE, `tcnt`=0, `bcnt`=0.
- **Reset mid-frame:** the frame is abandoned. After release, the receiver waits in IDLE for the next low `rx_s`; if the line is mid-frame, it resynchronizes on a later low, possibly mid-frame.
- **Input latency:** 2 `clk` from a `rx` transition to `rx_s`.
- **Completion:** OVERSAMPLE/2 + (DATA_BITS + P + STOP_BITS)·OVERSAMPLE ticks after the first low tick, where P = 1 if parity is enabled. `dout_valid` rises 1 `clk` after that tick.
- **`rx_busy`:** rises 1 `clk` after the IDLE→START tick; falls with the return to IDLE.
- **Ticks:** no state change occurs between ticks. Back-to-back `clk_en` (every clk) is legal.

## Structure
- Shared package `uart_pkg`:
  - parity-mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - the receiver state encoding;
  - a parity-check function (data, mode) → expected bit, reused by the transmitter.
- Sub-module `uart_sync2`: 2-flop synchronizer with a parameter for reset value (1 here).

## Test plan
- Defaults, OVERSAMPLE=16: send 0xA5 with even parity bit 0 and 1 stop bit → `dout`=0xA5, `dout_valid`=1, both error flags 0, latency 16·8+8+32 = 168 ticks after the first low.
- PARITY_MODE=2, DATA_BITS=7: send 0x41 with a wrong parity bit → `dout`=0x41, `parity_err`=1, `frame_err`=0.
- STOP_BITS=2: send 0x3C with the second stop bit low → `frame_err`=1, `dout`=0x3C.
- Glitch: `rx` low for 4 ticks, then high → no `dout_valid`; `rx_busy` pulses and returns to 0; next frame 0x55 is received correctly.
- Hold `dout_ready`=0, send 0x11 then 0x22 → `dout` stays 0x11 and `overrun`=1. Assert `dout_ready` for one cycle → `dout_valid` and `overrun` clear.
- Assert `rst` mid-DATA of 0xFF → all outputs 0 next cycle, no word delivered. A subsequent 0x81 is received clean.
